// File: rtl/video_source_scheduler.sv
// rtl/video_source_scheduler.sv - frame-synchronous pixel source scheduler for the hdmi rgb input
//
// Shares one rgb stream between several pixel generators. Source switches,
// whether manual or from auto rotation, only happen on the first pixel of a
// frame, so a frame is never split between two sources.

module video_source_scheduler #(
  parameter int NUM_SOURCES  = 4,
  parameter int DWELL_FRAMES = 60,
  parameter int SEL_W        = $clog2(NUM_SOURCES)
) (
  input  logic                      clk_pixel,
  input  logic                      RST,
  input  logic [9:0]                cx,
  input  logic [9:0]                cy,
  input  logic [24*NUM_SOURCES-1:0] src_rgb,
  input  logic                      auto_en,
  input  logic                      sel_req,
  input  logic [SEL_W-1:0]          sel_idx,
  output logic                      sel_ack,
  output logic [23:0]               rgb,
  output logic [SEL_W-1:0]          active_src,
  output logic [7:0]                frame_count,
  output logic                      frame_start
);

  // Dwell counter only needs to reach DWELL_FRAMES-1; keep at least one bit.
  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [DW-1:0]    DWELL_LAST  = DW'(DWELL_FRAMES - 1);
  localparam logic [SEL_W-1:0] LAST_SRC    = SEL_W'(NUM_SOURCES - 1);
  // One extra bit so a non-power-of-two source count can be compared safely.
  localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W + 1)'(NUM_SOURCES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ACKED   = 2'd2;

  logic             origin;
  logic             boundary;
  logic             origin_d_q;

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] req_idx_q, req_idx_d;
  logic             manual_apply;
  logic             req_in_range;
  logic             sel_ack_q, sel_ack_d;

  logic [SEL_W-1:0] active_src_q, active_src_d;
  logic [DW-1:0]    dwell_q, dwell_d;

  logic [7:0]       frame_count_q, frame_count_d;
  logic             frame_start_q;
  logic [23:0]      rgb_q, rgb_d;

  // A frame begins on the first cycle the raster sits at (0,0); holding
  // origin for several cycles must not produce repeated boundaries.
  assign origin   = (cx == 10'd0) && (cy == 10'd0);
  assign boundary = origin && !origin_d_q;

  assign req_in_range = ({1'b0, req_idx_q} < NUM_SRC_EXT);

  // Manual select handshake: latch the index on request, apply it on the next boundary.
  always_comb begin
    state_d      = state_q;
    req_idx_d    = req_idx_q;
    manual_apply = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_req) begin
          req_idx_d = sel_idx;
          state_d   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // Dropping the request wins even if it coincides with a boundary.
        if (!sel_req) begin
          state_d = ST_IDLE;
        end else if (boundary) begin
          manual_apply = 1'b1;
          state_d      = ST_ACKED;
        end
      end
      ST_ACKED: begin
        if (!sel_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    sel_ack_d = (state_d == ST_ACKED);
  end

  // Source selection: a pending manual switch beats auto rotation on a boundary.
  always_comb begin
    active_src_d = active_src_q;
    dwell_d      = dwell_q;
    if (manual_apply) begin
      // Out-of-range indices are acknowledged but leave the source alone.
      if (req_in_range) begin
        active_src_d = req_idx_q;
      end
      dwell_d = '0;
    end else if (boundary) begin
      if (!auto_en) begin
        dwell_d = '0;
      end else if (dwell_q == DWELL_LAST) begin
        dwell_d      = '0;
        active_src_d = (active_src_q == LAST_SRC) ? '0 : active_src_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Frame counter advances once per frame and wraps naturally at 8 bits.
  always_comb begin
    frame_count_d = frame_count_q;
    if (boundary) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Pixel mux uses the post-switch source so pixel (0,0) already comes from it.
  always_comb begin
    rgb_d = src_rgb[23:0];
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (active_src_d == SEL_W'(i)) begin
        rgb_d = src_rgb[24*i +: 24];
      end
    end
  end

  // Raster edge detector and frame bookkeeping registers.
  always_ff @(posedge clk_pixel or negedge RST) begin
    if (!RST) begin
      origin_d_q    <= 1'b0;
      frame_count_q <= 8'd0;
      frame_start_q <= 1'b0;
    end else begin
      origin_d_q    <= origin;
      frame_count_q <= frame_count_d;
      frame_start_q <= boundary;
    end
  end

  // Handshake state; reset drops any pending request and the acknowledge.
  always_ff @(posedge clk_pixel or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      req_idx_q <= '0;
      sel_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_idx_q <= req_idx_d;
      sel_ack_q <= sel_ack_d;
    end
  end

  // Active source and auto-rotation dwell counter.
  always_ff @(posedge clk_pixel or negedge RST) begin
    if (!RST) begin
      active_src_q <= '0;
      dwell_q      <= '0;
    end else begin
      active_src_q <= active_src_d;
      dwell_q      <= dwell_d;
    end
  end

  // Registered pixel output to hdmi.
  always_ff @(posedge clk_pixel or negedge RST) begin
    if (!RST) begin
      rgb_q <= 24'd0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign sel_ack     = sel_ack_q;
  assign rgb         = rgb_q;
  assign active_src  = active_src_q;
  assign frame_count = frame_count_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_source_scheduler.sv
// tb/tb_video_source_scheduler.sv - directed bench for video_source_scheduler on a 4x3 raster

module tb_video_source_scheduler;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk_pixel;
  logic        RST;
  logic [9:0]  cx, cy;
  logic [95:0] src_rgb4;
  logic [71:0] src_rgb3;
  logic        auto_en4, auto_en3;
  logic        sel_req4, sel_req3;
  logic [1:0]  sel_idx4, sel_idx3;
  logic        sel_ack4, sel_ack3;
  logic [23:0] rgb4, rgb3;
  logic [1:0]  active_src4, active_src3;
  logic [7:0]  frame_count4, frame_count3;
  logic        frame_start4, frame_start3;

  int          total;
  int          bad;
  logic [23:0] prev_rgb;
  bit          ack_seen_pre;

  // Generator pixel: source tag in the top nibble, then y, then x.
  function automatic logic [23:0] exp_pix(input int s, input logic [9:0] x, input logic [9:0] y);
    return {4'(s + 1), y, x};
  endfunction

  assign src_rgb4 = {exp_pix(3, cx, cy), exp_pix(2, cx, cy), exp_pix(1, cx, cy), exp_pix(0, cx, cy)};
  assign src_rgb3 = {exp_pix(2, cx, cy), exp_pix(1, cx, cy), exp_pix(0, cx, cy)};

  video_source_scheduler #(.NUM_SOURCES(4), .DWELL_FRAMES(2)) u4 (
    .clk_pixel(clk_pixel), .RST(RST), .cx(cx), .cy(cy), .src_rgb(src_rgb4),
    .auto_en(auto_en4), .sel_req(sel_req4), .sel_idx(sel_idx4), .sel_ack(sel_ack4),
    .rgb(rgb4), .active_src(active_src4), .frame_count(frame_count4), .frame_start(frame_start4)
  );

  video_source_scheduler #(.NUM_SOURCES(3), .DWELL_FRAMES(2)) u3 (
    .clk_pixel(clk_pixel), .RST(RST), .cx(cx), .cy(cy), .src_rgb(src_rgb3),
    .auto_en(auto_en3), .sel_req(sel_req3), .sel_idx(sel_idx3), .sel_ack(sel_ack3),
    .rgb(rgb3), .active_src(active_src3), .frame_count(frame_count3), .frame_start(frame_start3)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic next_pix();
    if (cx == 10'(W - 1)) begin
      cx = 10'd0;
      cy = (cy == 10'(H - 1)) ? 10'd0 : cy + 10'd1;
    end else begin
      cx = cx + 10'd1;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pixel);
      #1;
      next_pix();
    end
  endtask

  // Runs until frame_start is seen; outputs stay valid for the caller afterwards.
  task automatic wait_fs();
    bit got;
    got = 1'b0;
    ack_seen_pre = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      prev_rgb = rgb4;
      @(posedge clk_pixel);
      #1;
      if (frame_start4 === 1'b1) got = 1'b1;
      else if (sel_ack4 === 1'b1) ack_seen_pre = 1'b1;
      next_pix();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL wait_fs frame_start not seen within 40 cycles");
    end
  endtask

  task automatic req_select(input bit on3, input logic [1:0] idx);
    step(2);
    if (on3) begin
      sel_idx3 = idx;
      sel_req3 = 1'b1;
    end else begin
      sel_idx4 = idx;
      sel_req4 = 1'b1;
    end
    wait_fs();
  endtask

  task automatic drop_req();
    sel_req4 = 1'b0;
    sel_req3 = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    logic [23:0] e;
    RST = 1'b0;
    cx = 10'd0;
    cy = 10'd0;
    auto_en4 = 1'b0; auto_en3 = 1'b0;
    sel_req4 = 1'b0; sel_req3 = 1'b0;
    sel_idx4 = 2'd0; sel_idx3 = 2'd0;
    repeat (3) @(posedge clk_pixel);
    #1;
    total++; if (rgb4 !== 24'd0) begin bad++; $display("FAIL reset_rgb got=%0h exp=0", rgb4); end
    total++; if (active_src4 !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", active_src4); end
    total++; if (frame_count4 !== 8'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", frame_count4); end
    total++; if (frame_start4 !== 1'b0) begin bad++; $display("FAIL reset_fs got=%0b exp=0", frame_start4); end
    total++; if (sel_ack4 !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b exp=0", sel_ack4); end
    total++; if (rgb3 !== 24'd0) begin bad++; $display("FAIL reset_rgb3 got=%0h exp=0", rgb3); end
    RST = 1'b1;
    @(posedge clk_pixel);
    #1;
    total++; if (frame_start4 !== 1'b1) begin bad++; $display("FAIL first_fs got=%0b exp=1", frame_start4); end
    total++; if (frame_count4 !== 8'd1) begin bad++; $display("FAIL first_fc got=%0d exp=1", frame_count4); end
    total++; if (rgb4 !== exp_pix(0, 10'd0, 10'd0)) begin bad++; $display("FAIL first_rgb got=%0h exp=%0h", rgb4, exp_pix(0, 10'd0, 10'd0)); end
    next_pix();
    for (int i = 0; i < 3; i++) begin
      e = exp_pix(0, cx, cy);
      @(posedge clk_pixel);
      #1;
      total++; if (rgb4 !== e) begin bad++; $display("FAIL delay_rgb got=%0h exp=%0h", rgb4, e); end
      total++; if (frame_start4 !== 1'b0) begin bad++; $display("FAIL fs_single got=%0b exp=0", frame_start4); end
      next_pix();
    end
  endtask

  task automatic test_auto_rotation();
    int seq [9];
    seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    auto_en4 = 1'b1;
    total++; if (active_src4 !== 2'(seq[0])) begin bad++; $display("FAIL auto_f0 got=%0d exp=%0d", active_src4, seq[0]); end
    for (int k = 1; k < 9; k++) begin
      wait_fs();
      total++; if (active_src4 !== 2'(seq[k])) begin bad++; $display("FAIL auto_src f%0d got=%0d exp=%0d", k, active_src4, seq[k]); end
      total++; if (rgb4 !== exp_pix(seq[k], 10'd0, 10'd0)) begin bad++; $display("FAIL auto_pix00 f%0d got=%0h exp=%0h", k, rgb4, exp_pix(seq[k], 10'd0, 10'd0)); end
      total++; if (prev_rgb !== exp_pix(seq[k-1], 10'(W - 1), 10'(H - 1))) begin bad++; $display("FAIL auto_last f%0d got=%0h exp=%0h", k, prev_rgb, exp_pix(seq[k-1], 10'(W - 1), 10'(H - 1))); end
    end
    auto_en4 = 1'b0;
  endtask

  task automatic test_manual_handshake();
    step(2);
    sel_idx4 = 2'd2;
    sel_req4 = 1'b1;
    step(1);
    sel_idx4 = 2'd1;
    wait_fs();
    total++; if (ack_seen_pre !== 1'b0) begin bad++; $display("FAIL hs_early_ack got=%0b exp=0", ack_seen_pre); end
    total++; if (active_src4 !== 2'd2) begin bad++; $display("FAIL hs_src got=%0d exp=2", active_src4); end
    total++; if (rgb4 !== exp_pix(2, 10'd0, 10'd0)) begin bad++; $display("FAIL hs_pix00 got=%0h exp=%0h", rgb4, exp_pix(2, 10'd0, 10'd0)); end
    total++; if (sel_ack4 !== 1'b1) begin bad++; $display("FAIL hs_ack_rise got=%0b exp=1", sel_ack4); end
    step(3);
    total++; if (sel_ack4 !== 1'b1) begin bad++; $display("FAIL hs_ack_hold got=%0b exp=1", sel_ack4); end
    sel_req4 = 1'b0;
    @(posedge clk_pixel);
    #1;
    total++; if (sel_ack4 !== 1'b0) begin bad++; $display("FAIL hs_ack_fall got=%0b exp=0", sel_ack4); end
    next_pix();
  endtask

  task automatic test_priority();
    req_select(1'b0, 2'd0);
    drop_req();
    auto_en4 = 1'b1;
    wait_fs();
    total++; if (active_src4 !== 2'd0) begin bad++; $display("FAIL prio_dwell1 got=%0d exp=0", active_src4); end
    req_select(1'b0, 2'd3);
    total++; if (active_src4 !== 2'd3) begin bad++; $display("FAIL prio_manual got=%0d exp=3", active_src4); end
    total++; if (rgb4 !== exp_pix(3, 10'd0, 10'd0)) begin bad++; $display("FAIL prio_pix got=%0h exp=%0h", rgb4, exp_pix(3, 10'd0, 10'd0)); end
    drop_req();
    wait_fs();
    total++; if (active_src4 !== 2'd3) begin bad++; $display("FAIL prio_dwell_restart got=%0d exp=3", active_src4); end
    wait_fs();
    total++; if (active_src4 !== 2'd0) begin bad++; $display("FAIL prio_wrap got=%0d exp=0", active_src4); end
    auto_en4 = 1'b0;
  endtask

  task automatic test_abort();
    step(2);
    sel_idx4 = 2'd2;
    sel_req4 = 1'b1;
    step(2);
    sel_req4 = 1'b0;
    wait_fs();
    total++; if (ack_seen_pre !== 1'b0) begin bad++; $display("FAIL abort_ack_pre got=%0b exp=0", ack_seen_pre); end
    total++; if (active_src4 !== 2'd0) begin bad++; $display("FAIL abort_src got=%0d exp=0", active_src4); end
    total++; if (sel_ack4 !== 1'b0) begin bad++; $display("FAIL abort_ack got=%0b exp=0", sel_ack4); end
    total++; if (rgb4 !== exp_pix(0, 10'd0, 10'd0)) begin bad++; $display("FAIL abort_pix got=%0h exp=%0h", rgb4, exp_pix(0, 10'd0, 10'd0)); end
  endtask

  task automatic test_out_of_range();
    req_select(1'b1, 2'd1);
    total++; if (active_src3 !== 2'd1) begin bad++; $display("FAIL oor_setup got=%0d exp=1", active_src3); end
    drop_req();
    req_select(1'b1, 2'd3);
    total++; if (sel_ack3 !== 1'b1) begin bad++; $display("FAIL oor_ack got=%0b exp=1", sel_ack3); end
    total++; if (active_src3 !== 2'd1) begin bad++; $display("FAIL oor_src got=%0d exp=1", active_src3); end
    total++; if (rgb3 !== exp_pix(1, 10'd0, 10'd0)) begin bad++; $display("FAIL oor_pix got=%0h exp=%0h", rgb3, exp_pix(1, 10'd0, 10'd0)); end
    drop_req();
    total++; if (sel_ack3 !== 1'b0) begin bad++; $display("FAIL oor_ack_fall got=%0b exp=0", sel_ack3); end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] prev_fc, exp_fc;
    bit wrapped;
    wrapped = 1'b0;
    prev_fc = frame_count4;
    for (int f = 0; f < 300 && !wrapped; f++) begin
      wait_fs();
      exp_fc = prev_fc + 8'd1;
      total++; if (frame_count4 !== exp_fc) begin bad++; $display("FAIL fc_step got=%0d exp=%0d", frame_count4, exp_fc); end
      if (prev_fc == 8'hff && frame_count4 == 8'h00) wrapped = 1'b1;
      prev_fc = frame_count4;
    end
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL fc_wrap got=%0b exp=1", wrapped); end
  endtask

  task automatic test_async_reset_acked();
    req_select(1'b0, 2'd2);
    total++; if (sel_ack4 !== 1'b1) begin bad++; $display("FAIL ar_pre_ack got=%0b exp=1", sel_ack4); end
    #2;
    RST = 1'b0;
    #1;
    total++; if (sel_ack4 !== 1'b0) begin bad++; $display("FAIL ar_ack got=%0b exp=0", sel_ack4); end
    total++; if (rgb4 !== 24'd0) begin bad++; $display("FAIL ar_rgb got=%0h exp=0", rgb4); end
    total++; if (active_src4 !== 2'd0) begin bad++; $display("FAIL ar_src got=%0d exp=0", active_src4); end
    step(3);
    if (cx == 10'd0 && cy == 10'd0) next_pix();
    RST = 1'b1;
    step(1);
    total++; if (sel_ack4 !== 1'b0) begin bad++; $display("FAIL ar_pending_ack got=%0b exp=0", sel_ack4); end
    wait_fs();
    total++; if (active_src4 !== 2'd2) begin bad++; $display("FAIL ar_rereq_src got=%0d exp=2", active_src4); end
    total++; if (sel_ack4 !== 1'b1) begin bad++; $display("FAIL ar_rereq_ack got=%0b exp=1", sel_ack4); end
    total++; if (frame_count4 !== 8'd1) begin bad++; $display("FAIL ar_fc got=%0d exp=1", frame_count4); end
    drop_req();
    total++; if (sel_ack4 !== 1'b0) begin bad++; $display("FAIL ar_ack_fall got=%0b exp=0", sel_ack4); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    prev_rgb = 24'd0;
    ack_seen_pre = 1'b0;
    test_reset();
    test_auto_rotation();
    test_manual_handshake();
    test_priority();
    test_abort();
    test_out_of_range();
    test_frame_wrap();
    test_async_reset_acked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
